// File: rtl/lagd_pkg.sv
// Shared types and constants for the LAGD island control registers.
// Holds reg-bus structs, register offsets, bit indices and state enums.
package lagd_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } lagd_reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } lagd_reg_rsp_t;

    localparam logic [7:0] OffCtrl     = 8'h00;
    localparam logic [7:0] OffStatus   = 8'h04;
    localparam logic [7:0] OffNumIter  = 8'h08;
    localparam logic [7:0] OffTimeout  = 8'h0C;
    localparam logic [7:0] OffCycleCnt = 8'h10;
    localparam logic [7:0] OffIterCnt  = 8'h14;
    localparam logic [7:0] OffId       = 8'h18;

    localparam int unsigned CtrlStart  = 0;
    localparam int unsigned CtrlAbort  = 1;
    localparam int unsigned CtrlIrqClr = 2;

    localparam int unsigned StatBusy    = 0;
    localparam int unsigned StatDone    = 1;
    localparam int unsigned StatAborted = 2;
    localparam int unsigned StatTimeout = 3;

    localparam logic [31:0] IdBase = 32'h0000_0000;

    typedef enum logic [1:0] {
        JobIdle = 2'd0,
        JobRun  = 2'd1,
        JobDone = 2'd2
    } lagd_job_state_e;

    typedef enum logic {
        HsIdle = 1'b0,
        HsResp = 1'b1
    } lagd_hs_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [31:0] strb_merge(
        input logic [31:0] old_v,
        input logic [31:0] wd,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/lagd_job_fsm.sv
// Island job state machine: start/abort pulses, iteration and cycle
// counters, timeout detection and the sticky result flags.
module lagd_job_fsm
    import lagd_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic        irq_clr_i,
    input  logic        iter_done_i,
    input  logic [31:0] num_iter_i,
    input  logic [31:0] timeout_i,
    output logic        core_start_o,
    output logic        core_abort_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        aborted_o,
    output logic        timeout_o,
    output logic [31:0] cycle_cnt_o,
    output logic [31:0] iter_cnt_o,
    output logic        irq_o
);

    lagd_job_state_e state_q, state_d;
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] iter_q, iter_d;
    logic [31:0] iter_inc;
    logic        done_q, done_d;
    logic        abrt_q, abrt_d;
    logic        tmo_q, tmo_d;
    logic        start_p_q, start_p_d;
    logic        abort_p_q, abort_p_d;
    logic        irq_q;
    logic        tmo_hit;

    assign iter_inc = iter_done_i ? sat_inc(iter_q) : iter_q;
    assign tmo_hit  = (timeout_i != 32'd0) && (cyc_q == timeout_i);

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        iter_d    = iter_q;
        done_d    = done_q;
        abrt_d    = abrt_q;
        tmo_d     = tmo_q;
        start_p_d = 1'b0;
        abort_p_d = 1'b0;
        unique case (state_q)
            JobIdle, JobDone: begin
                if (start_i) begin
                    done_d = 1'b0;
                    abrt_d = 1'b0;
                    tmo_d  = 1'b0;
                    if (num_iter_i != 32'd0) begin
                        cyc_d     = '0;
                        iter_d    = '0;
                        start_p_d = 1'b1;
                        state_d   = JobRun;
                    end else begin
                        done_d  = 1'b1;
                        state_d = JobDone;
                    end
                end else if (irq_clr_i) begin
                    done_d  = 1'b0;
                    abrt_d  = 1'b0;
                    tmo_d   = 1'b0;
                    state_d = JobIdle;
                end
            end
            JobRun: begin
                // abort beats timeout beats iteration completion
                if (abort_i) begin
                    done_d    = 1'b1;
                    abrt_d    = 1'b1;
                    abort_p_d = 1'b1;
                    state_d   = JobDone;
                end else if (tmo_hit) begin
                    done_d    = 1'b1;
                    tmo_d     = 1'b1;
                    abort_p_d = 1'b1;
                    state_d   = JobDone;
                end else begin
                    iter_d = iter_inc;
                    if (iter_inc >= num_iter_i) begin
                        done_d  = 1'b1;
                        state_d = JobDone;
                    end else begin
                        cyc_d = sat_inc(cyc_q);
                    end
                end
            end
            default: state_d = JobIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= JobIdle;
            cyc_q     <= '0;
            iter_q    <= '0;
            done_q    <= 1'b0;
            abrt_q    <= 1'b0;
            tmo_q     <= 1'b0;
            start_p_q <= 1'b0;
            abort_p_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            iter_q    <= iter_d;
            done_q    <= done_d;
            abrt_q    <= abrt_d;
            tmo_q     <= tmo_d;
            start_p_q <= start_p_d;
            abort_p_q <= abort_p_d;
            irq_q     <= done_d | abrt_d | tmo_d;
        end
    end

    assign core_start_o = start_p_q;
    assign core_abort_o = abort_p_q;
    assign busy_o       = (state_q == JobRun);
    assign done_o       = done_q;
    assign aborted_o    = abrt_q;
    assign timeout_o    = tmo_q;
    assign cycle_cnt_o  = cyc_q;
    assign iter_cnt_o   = iter_q;
    assign irq_o        = irq_q;

endmodule

// File: rtl/lagd_island_ctrl_regs.sv
// Per-island reg-bus responder: decodes the control/status window
// and drives the island job state machine.
module lagd_island_ctrl_regs
    import lagd_pkg::*;
#(
    parameter type         reg_req_t = lagd_reg_req_t,
    parameter type         reg_rsp_t = lagd_reg_rsp_t,
    parameter int unsigned IslandIdx = 0,
    parameter int unsigned AddrOffW  = 8
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  reg_req_t reg_req_i,
    output reg_rsp_t reg_rsp_o,
    output logic     core_start_o,
    output logic     core_abort_o,
    input  logic     core_iter_done_i,
    output logic     irq_o
);

    lagd_hs_state_e hs_q;

    logic [AddrOffW-1:0] off;
    logic        accept;
    logic        req_err;
    logic        wr_ok;
    logic        hit;
    logic        is_ro;
    logic        is_ctrl;
    logic        is_num;
    logic        is_tmo;
    logic [31:0] rd_val;
    logic [31:0] num_iter_q;
    logic [31:0] timeout_q;
    logic [31:0] rdata_q;
    logic        error_q;
    logic [31:0] cycle_cnt;
    logic [31:0] iter_cnt;
    logic [3:0]  status;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        timed_out;
    logic        ctrl_wr;
    logic        job_start;
    logic        job_abort;
    logic        job_irq_clr;
    logic        unused_addr;

    // window base bits are routed by the demux and not decoded here
    assign unused_addr = ^reg_req_i.addr;

    assign accept = (hs_q == HsIdle) && reg_req_i.valid;
    assign off    = reg_req_i.addr[AddrOffW-1:0];

    always_comb begin
        status              = '0;
        status[StatBusy]    = busy;
        status[StatDone]    = done;
        status[StatAborted] = aborted;
        status[StatTimeout] = timed_out;
    end

    always_comb begin
        hit     = 1'b0;
        is_ro   = 1'b0;
        is_ctrl = 1'b0;
        is_num  = 1'b0;
        is_tmo  = 1'b0;
        rd_val  = '0;
        unique case (off)
            AddrOffW'(OffCtrl): begin
                hit     = 1'b1;
                is_ctrl = 1'b1;
            end
            AddrOffW'(OffStatus): begin
                hit    = 1'b1;
                is_ro  = 1'b1;
                rd_val = {28'd0, status};
            end
            AddrOffW'(OffNumIter): begin
                hit    = 1'b1;
                is_num = 1'b1;
                rd_val = num_iter_q;
            end
            AddrOffW'(OffTimeout): begin
                hit    = 1'b1;
                is_tmo = 1'b1;
                rd_val = timeout_q;
            end
            AddrOffW'(OffCycleCnt): begin
                hit    = 1'b1;
                is_ro  = 1'b1;
                rd_val = cycle_cnt;
            end
            AddrOffW'(OffIterCnt): begin
                hit    = 1'b1;
                is_ro  = 1'b1;
                rd_val = iter_cnt;
            end
            AddrOffW'(OffId): begin
                hit    = 1'b1;
                is_ro  = 1'b1;
                rd_val = IdBase + 32'(IslandIdx);
            end
            default: ;
        endcase
    end

    assign req_err = !hit
                   || (off[1:0] != 2'b00)
                   || (reg_req_i.write && is_ro)
                   || (!reg_req_i.write && is_ctrl);

    assign wr_ok       = accept && reg_req_i.write && !req_err;
    assign ctrl_wr     = wr_ok && is_ctrl && reg_req_i.wstrb[0];
    assign job_start   = ctrl_wr && reg_req_i.wdata[CtrlStart];
    assign job_abort   = ctrl_wr && reg_req_i.wdata[CtrlAbort];
    assign job_irq_clr = ctrl_wr && reg_req_i.wdata[CtrlIrqClr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hs_q       <= HsIdle;
            rdata_q    <= '0;
            error_q    <= 1'b0;
            num_iter_q <= '0;
            timeout_q  <= '0;
        end else begin
            hs_q    <= accept ? HsResp : HsIdle;
            rdata_q <= '0;
            error_q <= 1'b0;
            if (accept) begin
                error_q <= req_err;
                if (!req_err && !reg_req_i.write) rdata_q <= rd_val;
            end
            if (wr_ok && is_num) begin
                num_iter_q <= strb_merge(num_iter_q, reg_req_i.wdata,
                                         reg_req_i.wstrb);
            end
            if (wr_ok && is_tmo) begin
                timeout_q <= strb_merge(timeout_q, reg_req_i.wdata,
                                        reg_req_i.wstrb);
            end
        end
    end

    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.rdata = rdata_q;
        reg_rsp_o.error = error_q;
        reg_rsp_o.ready = (hs_q == HsResp);
    end

    lagd_job_fsm u_job_fsm (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (job_start),
        .abort_i      (job_abort),
        .irq_clr_i    (job_irq_clr),
        .iter_done_i  (core_iter_done_i),
        .num_iter_i   (num_iter_q),
        .timeout_i    (timeout_q),
        .core_start_o (core_start_o),
        .core_abort_o (core_abort_o),
        .busy_o       (busy),
        .done_o       (done),
        .aborted_o    (aborted),
        .timeout_o    (timed_out),
        .cycle_cnt_o  (cycle_cnt),
        .iter_cnt_o   (iter_cnt),
        .irq_o        (irq_o)
    );

endmodule

// File: tb/tb_lagd_island_ctrl_regs.sv
// Directed bench for lagd_island_ctrl_regs: register access,
// job start/iterate/timeout/abort flows and reset during a response.
module tb_lagd_island_ctrl_regs;
    import lagd_pkg::*;

    logic          clk = 1'b0;
    logic          rst_ni;
    lagd_reg_req_t req;
    lagd_reg_rsp_t rsp;
    logic          core_start;
    logic          core_abort;
    logic          iter_done;
    logic          irq;

    int total = 0;
    int bad   = 0;
    int n_start = 0;
    int n_abort = 0;
    int s0;
    int a0;
    logic [31:0] r;
    logic        e;

    always #5 clk = ~clk;

    lagd_island_ctrl_regs #(
        .IslandIdx (3),
        .AddrOffW  (8)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .reg_req_i        (req),
        .reg_rsp_o        (rsp),
        .core_start_o     (core_start),
        .core_abort_o     (core_abort),
        .core_iter_done_i (iter_done),
        .irq_o            (irq)
    );

    always @(negedge clk) begin
        if (core_start) n_start++;
        if (core_abort) n_abort++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bus(input logic [7:0] a, input logic we,
                       input logic [31:0] wd, input logic [3:0] st,
                       input logic it, output logic [31:0] rd,
                       output logic er);
        int n;
        req.addr  = 32'h4000_0300 | {24'd0, a};
        req.write = we;
        req.wdata = wd;
        req.wstrb = st;
        req.valid = 1'b1;
        iter_done = it;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            iter_done = 1'b0;
            n++;
        end while (!rsp.ready && n < 8);
        chk("lat", 32'(n), 32'd1);
        rd = rsp.rdata;
        er = rsp.error;
        req.valid = 1'b0;
        req.write = 1'b0;
        @(posedge clk);
        #1;
        chk("rdy1cyc", 32'(rsp.ready), 32'd0);
    endtask

    task automatic wr(input string tag, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] st,
                      input logic exp_err);
        logic [31:0] rr;
        logic        ee;
        bus(a, 1'b1, d, st, 1'b0, rr, ee);
        chk({tag, ".err"}, 32'(ee), 32'(exp_err));
    endtask

    task automatic rdchk(input string tag, input logic [7:0] a,
                         input logic [31:0] exp_d, input logic exp_err);
        logic [31:0] rr;
        logic        ee;
        bus(a, 1'b0, 32'd0, 4'h0, 1'b0, rr, ee);
        chk({tag, ".err"}, 32'(ee), 32'(exp_err));
        chk({tag, ".data"}, rr, exp_d);
    endtask

    task automatic pulse_iter();
        iter_done = 1'b1;
        @(posedge clk);
        #1;
        iter_done = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        req       = '0;
        iter_done = 1'b0;
        rst_ni    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready", 32'(rsp.ready), 32'd0);
        chk("rst.error", 32'(rsp.error), 32'd0);
        chk("rst.rdata", rsp.rdata, 32'd0);
        chk("rst.start", 32'(core_start), 32'd0);
        chk("rst.abort", 32'(core_abort), 32'd0);
        chk("rst.irq", 32'(irq), 32'd0);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        rdchk("id", 8'h18, 32'd3, 1'b0);
        wr("ni.strb", 8'h08, 32'hAABB_0004, 4'b0011, 1'b0);
        rdchk("ni.strb", 8'h08, 32'h0000_0004, 1'b0);

        wr("ni3", 8'h08, 32'd3, 4'hF, 1'b0);
        s0 = n_start;
        wr("go", 8'h00, 32'h1, 4'h1, 1'b0);
        rdchk("st.busy", 8'h04, 32'h1, 1'b0);
        repeat (3) pulse_iter();
        repeat (2) @(posedge clk);
        #1;
        rdchk("st.done", 8'h04, 32'h2, 1'b0);
        chk("irq.done", 32'(irq), 32'd1);
        rdchk("itercnt", 8'h14, 32'd3, 1'b0);
        chk("nstart.1", 32'(n_start - s0), 32'd1);

        wr("clr", 8'h00, 32'h4, 4'h1, 1'b0);
        wr("tmo10", 8'h0C, 32'd10, 4'hF, 1'b0);
        wr("ni100", 8'h08, 32'd100, 4'hF, 1'b0);
        a0 = n_abort;
        wr("go2", 8'h00, 32'h1, 4'h1, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("nabort.tmo", 32'(n_abort - a0), 32'd1);
        rdchk("cyccnt", 8'h10, 32'd10, 1'b0);
        rdchk("st.tmo", 8'h04, 32'hA, 1'b0);
        chk("irq.tmo", 32'(irq), 32'd1);
        wr("clr2", 8'h00, 32'h4, 4'h1, 1'b0);
        rdchk("st.clr", 8'h04, 32'h0, 1'b0);
        chk("irq.clr", 32'(irq), 32'd0);

        wr("tmo0", 8'h0C, 32'd0, 4'hF, 1'b0);
        wr("ni2", 8'h08, 32'd2, 4'hF, 1'b0);
        s0 = n_start;
        a0 = n_abort;
        wr("go3", 8'h00, 32'h1, 4'h1, 1'b0);
        pulse_iter();
        wr("go.run", 8'h00, 32'h1, 4'h1, 1'b0);
        bus(8'h00, 1'b1, 32'h2, 4'h1, 1'b1, r, e);
        chk("abort.err", 32'(e), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rdchk("st.abort", 8'h04, 32'h6, 1'b0);
        chk("nstart.run", 32'(n_start - s0), 32'd1);
        chk("nabort.ab", 32'(n_abort - a0), 32'd1);

        wr("clr3", 8'h00, 32'h4, 4'h1, 1'b0);
        s0 = n_start;
        wr("ro.st", 8'h04, 32'hFFFF_FFFF, 4'hF, 1'b1);
        rdchk("unmap", 8'h1C, 32'd0, 1'b1);
        rdchk("misal", 8'h02, 32'd0, 1'b1);
        rdchk("ctrl.rd", 8'h00, 32'd0, 1'b1);
        wr("ro.id", 8'h18, 32'd0, 4'hF, 1'b1);
        wr("misal.wr", 8'h09, 32'hFFFF_FFFF, 4'hF, 1'b1);
        wr("nostrb", 8'h00, 32'h1, 4'b1110, 1'b0);
        rdchk("ni.keep", 8'h08, 32'd2, 1'b0);
        rdchk("st.keep", 8'h04, 32'h0, 1'b0);
        chk("nstart.err", 32'(n_start - s0), 32'd0);

        wr("ni0", 8'h08, 32'd0, 4'hF, 1'b0);
        s0 = n_start;
        wr("go0", 8'h00, 32'h1, 4'h1, 1'b0);
        rdchk("st.zero", 8'h04, 32'h2, 1'b0);
        chk("irq.zero", 32'(irq), 32'd1);
        chk("nstart.0", 32'(n_start - s0), 32'd0);

        wr("ni5", 8'h08, 32'd5, 4'hF, 1'b0);
        req.addr  = 32'h0000_0018;
        req.write = 1'b0;
        req.valid = 1'b1;
        @(posedge clk);
        #1;
        chk("resp.ready", 32'(rsp.ready), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("rstresp.ready", 32'(rsp.ready), 32'd0);
        chk("rstresp.rdata", rsp.rdata, 32'd0);
        chk("rstresp.irq", 32'(irq), 32'd0);
        req.valid = 1'b0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        rdchk("ni.rst", 8'h08, 32'd0, 1'b0);
        rdchk("st.rst", 8'h04, 32'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
